alu_iter_unit: RTL and testbench
================================

Name: alu_iter_unit

Overview:
Sequential successor to the combinational ALU decoder, used in the multicycle RISC-V datapath. It decodes ALUD/funct3/funct7 into a full RV32I ALU operation and executes it behind a valid/ready handshake. Non-shift ops complete in one cycle. Shifts run iteratively, SHIFT_STEP bit positions per cycle. The 4-bit ALUOp is exported so the legacy 2-bit encodings stay recognisable.

Parameters:
XLEN, 32, operand/result width (power of 2, >=8)
SHIFT_STEP, 1, bit positions shifted per cycle in SHIFT state (power of 2, 1..XLEN)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operation request
in_ready  output  1  unit can accept (high only in IDLE)
ALUD  input  1  0: force ADD (load/store/address); 1: decode F/F7
R  input  1  1: R-type (F7 honoured for ADD/SUB); 0: I-type
F  input  3  funct3
F7  input  1  funct7 bit 5
A  input  XLEN  operand A
B  input  XLEN  operand B / immediate
out_valid  output  1  result available
out_ready  input  1  consumer takes result
Y  output  XLEN  result
Z  output  1  Y == 0
ALUOp  output  4  decoded operation of the current/last op

Behaviour:
- One clock (clk). Reset is asynchronous, active-low (rst_n). Reset forces state IDLE, Y=0, Z=1, ALUOp=0000, out_valid=0. in_ready is 1 in IDLE, including during reset.
- Decode (captured at accept):
  - ALUD=0 -> ADD.
  - ALUD=1, by F: 000 -> SUB if R&F7 else ADD; 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 -> SRA if F7 else SRL (for R and I types); 110 OR; 111 AND.
- ALUOp encodings: ADD 0000, XOR 0001, AND 0010, SRA 0011 (low bits match legacy ALUOp), SUB 0100, SLL 0101, SRL 0110, SLT 0111, SLTU 1000, OR 1001. 1010-1111 unused.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: in_ready=1.
  - On in_valid: latch A, B, ALUOp.
    - Non-shift op: Y computed and registered; go to DONE next edge (latency 1).
    - Shift op: shamt = B[log2(XLEN)-1:0]; upper bits of B ignored. Working reg = A.
      - shamt=0: go straight to DONE, Y=A.
      - otherwise go to SHIFT.
  - SHIFT: each cycle shift by min(SHIFT_STEP, remaining). SRA fills with the sign of A; SRL/SLL fill with 0. Go to DONE when remaining reaches 0.
  - Total latency accept->out_valid = 1 + ceil(shamt/SHIFT_STEP) cycles.
  - DONE: out_valid=1; Y, Z, ALUOp held stable. On out_ready go to IDLE. No new accept in the same cycle, so max throughput is 1 op per 2 cycles.
- Arithmetic:
  - ADD/SUB modulo 2^XLEN, no overflow flag.
  - SLT signed, SLTU unsigned; result is 0 or 1, zero-extended.
- in_valid while not in IDLE is ignored; inputs are not sampled.
- Reset mid-operation (SHIFT or DONE) aborts immediately. The result is discarded, out_valid drops asynchronously, and the first cycle after release is IDLE.
- Z is registered together with Y.

Decomposition:
- Package alu_pkg: ALUOp localparams (the 10 codes above), FSM state encodings, and the function clog2 used for the shamt width.
- One sub-module is natural: alu_op_decode, purely combinational (ALUD, R, F, F7 -> ALUOp[3:0]). It is the direct extension of the legacy decoder and is reused by the single-cycle core.

Test Plan:
1. Legacy decode (XLEN=32, SHIFT_STEP=1): ALUD=0, F=100, A=5, B=3 -> ALUOp=0000, Y=8, out_valid 1 cycle after accept. ALUD=1, F=100/111/101(F7=1) -> ALUOp 0001/0010/0011.
2. SUB and zero flag: ALUD=1, R=1, F7=1, F=000, A=3, B=5 -> ALUOp=0100, Y=0xFFFFFFFE, Z=0. Then A=B=7 -> Y=0, Z=1. Same F with R=0 -> ADD, Y=14.
3. Iterative shift: SRA, A=0x80000000, B=4 -> Y=0xF8000000, out_valid 5 cycles after accept. B=0x24 (shamt 4) -> identical. SLL, B=0 -> Y=A, latency 1. SRL, A=0xFFFFFFFF, B=31 -> Y=1, latency 32. Rerun with SHIFT_STEP=8: B=31 -> latency 5.
4. Backpressure: hold out_ready=0 for 3 cycles in DONE -> Y/Z/ALUOp stable, in_ready=0; an in_valid pulse with new operands is ignored. out_ready=1 -> IDLE next cycle.
5. Reset mid-shift: start SLL with B=31, drop rst_n at cycle 10 -> out_valid=0 and Y=0 immediately. After release, in_ready=1; ADD 1+1 -> Y=2.
6. Compare: A=0xFFFFFFFF, B=1 -> SLT gives Y=1; SLTU gives Y=0 and Z=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU operation codes, FSM state type and helpers for the iterative ALU.
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_XOR  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_SRA  = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;
  localparam logic [3:0] ALU_OR   = 4'b1001;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } alu_state_t;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    while ((32'd1 << res) < value) res = res + 1;
    return res;
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational RV32I ALU decoder: ALUD/funct3/funct7 -> 4-bit ALUOp.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic       i_alud,
  input  logic       i_r,
  input  logic [2:0] i_f,
  input  logic       i_f7,
  output logic [3:0] o_alu_op_c
);

  always_comb begin
    o_alu_op_c = ALU_ADD;
    if (i_alud) begin
      case (i_f)
        3'b000:  o_alu_op_c = (i_r && i_f7) ? ALU_SUB : ALU_ADD;
        3'b001:  o_alu_op_c = ALU_SLL;
        3'b010:  o_alu_op_c = ALU_SLT;
        3'b011:  o_alu_op_c = ALU_SLTU;
        3'b100:  o_alu_op_c = ALU_XOR;
        3'b101:  o_alu_op_c = i_f7 ? ALU_SRA : ALU_SRL;
        3'b110:  o_alu_op_c = ALU_OR;
        default: o_alu_op_c = ALU_AND;
      endcase
    end
  end

endmodule

// File: rtl/alu_iter_unit.sv
// Multicycle ALU: single-cycle logic/arith ops, iterative shifter, valid/ready on both sides.
module alu_iter_unit
  import alu_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned SHIFT_STEP = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            ALUD,
  input  logic            R,
  input  logic [2:0]      F,
  input  logic            F7,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] Y,
  output logic            Z,
  output logic [3:0]      ALUOp
);

  localparam int unsigned SH_W  = clog2(XLEN);
  localparam int unsigned CNT_W = SH_W + 1;
  localparam logic [CNT_W-1:0] STEP = CNT_W'(SHIFT_STEP);

  alu_state_t       r_state;
  logic [XLEN-1:0]  r_work;
  logic [CNT_W-1:0] r_cnt;
  logic [XLEN-1:0]  r_y;
  logic             r_z;
  logic [3:0]       r_op;

  logic [3:0]       w_op;
  logic             w_is_shift;
  logic [CNT_W-1:0] w_shamt;
  logic [XLEN-1:0]  w_alu_y;
  logic [CNT_W-1:0] w_amt;
  logic [XLEN-1:0]  w_shifted;

  alu_op_decode u_dec (
    .i_alud     (ALUD),
    .i_r        (R),
    .i_f        (F),
    .i_f7       (F7),
    .o_alu_op_c (w_op)
  );

  assign w_is_shift = (w_op == ALU_SLL) || (w_op == ALU_SRL) || (w_op == ALU_SRA);
  assign w_shamt    = CNT_W'(B[SH_W-1:0]);

  // Single-cycle result path, evaluated on the live operands at accept.
  always_comb begin
    w_alu_y = '0;
    case (w_op)
      ALU_ADD:  w_alu_y = A + B;
      ALU_SUB:  w_alu_y = A - B;
      ALU_XOR:  w_alu_y = A ^ B;
      ALU_AND:  w_alu_y = A & B;
      ALU_OR:   w_alu_y = A | B;
      ALU_SLT:  w_alu_y = XLEN'($signed(A) < $signed(B));
      ALU_SLTU: w_alu_y = XLEN'(A < B);
      default:  w_alu_y = '0;
    endcase
  end

  // One shifter step of at most SHIFT_STEP positions on the working register.
  always_comb begin
    w_amt     = (r_cnt > STEP) ? STEP : r_cnt;
    w_shifted = r_work >> w_amt;
    case (r_op)
      ALU_SLL: w_shifted = r_work << w_amt;
      ALU_SRA: w_shifted = XLEN'($signed(r_work) >>> w_amt);
      default: w_shifted = r_work >> w_amt;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_work  <= '0;
      r_cnt   <= '0;
      r_y     <= '0;
      r_z     <= 1'b1;
      r_op    <= ALU_ADD;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_op <= w_op;
            if (w_is_shift) begin
              r_work <= A;
              r_cnt  <= w_shamt;
              if (w_shamt == '0) begin
                r_y     <= A;
                r_z     <= (A == '0);
                r_state <= ST_DONE;
              end else begin
                r_state <= ST_SHIFT;
              end
            end else begin
              r_y     <= w_alu_y;
              r_z     <= (w_alu_y == '0);
              r_state <= ST_DONE;
            end
          end
        end
        ST_SHIFT: begin
          r_work <= w_shifted;
          r_cnt  <= r_cnt - w_amt;
          if (r_cnt == w_amt) begin
            r_y     <= w_shifted;
            r_z     <= (w_shifted == '0);
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign Y         = r_y;
  assign Z         = r_z;
  assign ALUOp     = r_op;

endmodule

// File: tb/tb_alu_iter_unit.sv
// Directed, table-driven bench for alu_iter_unit (SHIFT_STEP=1 and SHIFT_STEP=8 instances).
module tb_alu_iter_unit;

  logic        clk;
  logic        rst_n;
  logic        ALUD, R, F7;
  logic [2:0]  F;
  logic [31:0] A, B;

  logic        iv1, ir1, ov1, or1, z1;
  logic [31:0] y1;
  logic [3:0]  op1;
  logic        iv8, ir8, ov8, or8, z8;
  logic [31:0] y8;
  logic [3:0]  op8;

  int checks = 0;
  int errors = 0;

  alu_iter_unit #(.XLEN(32), .SHIFT_STEP(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1),
    .ALUD(ALUD), .R(R), .F(F), .F7(F7), .A(A), .B(B),
    .out_valid(ov1), .out_ready(or1), .Y(y1), .Z(z1), .ALUOp(op1)
  );

  alu_iter_unit #(.XLEN(32), .SHIFT_STEP(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
    .ALUD(ALUD), .R(R), .F(F), .F7(F7), .A(A), .B(B),
    .out_valid(ov8), .out_ready(or8), .Y(y8), .Z(z8), .ALUOp(op8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        alud;
    logic        r;
    logic [2:0]  f;
    logic        f7;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_y;
    logic        exp_z;
    logic [3:0]  exp_op;
    int          exp_lat;
  } vec_t;

  localparam int NV = 15;
  vec_t tbl [NV];
  vec_t tbl8 [3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    ALUD = v.alud; R = v.r; F = v.f; F7 = v.f7; A = v.a; B = v.b;
  endtask

  // Issue one op, count edges from the accept edge until out_valid, then pop it.
  task automatic run_op(input bit sel, input vec_t v, output logic [31:0] y,
                        output logic z, output logic [3:0] op, output int lat);
    int guard;
    guard = 0;
    while (!(sel ? ir8 : ir1) && guard < 100) begin
      @(posedge clk); #1; guard++;
    end
    drive(v);
    if (sel) iv8 = 1'b1; else iv1 = 1'b1;
    @(posedge clk); #1;
    iv1 = 1'b0; iv8 = 1'b0;
    lat = 1;
    while (!(sel ? ov8 : ov1) && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    y  = sel ? y8 : y1;
    z  = sel ? z8 : z1;
    op = sel ? op8 : op1;
    if (sel) or8 = 1'b1; else or1 = 1'b1;
    @(posedge clk); #1;
    or1 = 1'b0; or8 = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ry;
    logic        rz;
    logic [3:0]  rop;
    int          rlat;
    vec_t        v;

    //             alud r  f       f7 a             b             y             z  op       lat
    tbl[0]  = '{1'b0, 1'b0, 3'b100, 1'b0, 32'd5,        32'd3,        32'd8,        1'b0, 4'b0000, 1};
    tbl[1]  = '{1'b1, 1'b0, 3'b100, 1'b0, 32'd5,        32'd3,        32'd6,        1'b0, 4'b0001, 1};
    tbl[2]  = '{1'b1, 1'b0, 3'b111, 1'b0, 32'd6,        32'd3,        32'd2,        1'b0, 4'b0010, 1};
    tbl[3]  = '{1'b1, 1'b0, 3'b101, 1'b1, 32'h80000000, 32'd4,        32'hF8000000, 1'b0, 4'b0011, 5};
    tbl[4]  = '{1'b1, 1'b0, 3'b101, 1'b1, 32'h80000000, 32'h24,       32'hF8000000, 1'b0, 4'b0011, 5};
    tbl[5]  = '{1'b1, 1'b1, 3'b000, 1'b1, 32'd3,        32'd5,        32'hFFFFFFFE, 1'b0, 4'b0100, 1};
    tbl[6]  = '{1'b1, 1'b1, 3'b000, 1'b1, 32'd7,        32'd7,        32'd0,        1'b1, 4'b0100, 1};
    tbl[7]  = '{1'b1, 1'b0, 3'b000, 1'b1, 32'd7,        32'd7,        32'd14,       1'b0, 4'b0000, 1};
    tbl[8]  = '{1'b1, 1'b0, 3'b001, 1'b0, 32'h1234,     32'd0,        32'h1234,     1'b0, 4'b0101, 1};
    tbl[9]  = '{1'b1, 1'b0, 3'b101, 1'b0, 32'hFFFFFFFF, 32'd31,       32'd1,        1'b0, 4'b0110, 32};
    tbl[10] = '{1'b1, 1'b0, 3'b010, 1'b0, 32'hFFFFFFFF, 32'd1,        32'd1,        1'b0, 4'b0111, 1};
    tbl[11] = '{1'b1, 1'b0, 3'b011, 1'b0, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b1, 4'b1000, 1};
    tbl[12] = '{1'b1, 1'b0, 3'b110, 1'b0, 32'hF0,       32'h0F,       32'hFF,       1'b0, 4'b1001, 1};
    tbl[13] = '{1'b1, 1'b1, 3'b001, 1'b0, 32'd1,        32'd31,       32'h80000000, 1'b0, 4'b0101, 32};
    tbl[14] = '{1'b1, 1'b0, 3'b010, 1'b0, 32'd1,        32'hFFFFFFFF, 32'd0,        1'b1, 4'b0111, 1};

    tbl8[0] = '{1'b1, 1'b0, 3'b101, 1'b0, 32'hFFFFFFFF, 32'd31,       32'd1,        1'b0, 4'b0110, 5};
    tbl8[1] = '{1'b1, 1'b0, 3'b101, 1'b1, 32'h80000000, 32'd4,        32'hF8000000, 1'b0, 4'b0011, 2};
    tbl8[2] = '{1'b1, 1'b0, 3'b001, 1'b0, 32'd1,        32'd9,        32'h200,      1'b0, 4'b0101, 3};

    rst_n = 1'b0; iv1 = 1'b0; iv8 = 1'b0; or1 = 1'b0; or8 = 1'b0;
    ALUD = 1'b0; R = 1'b0; F = 3'b000; F7 = 1'b0; A = '0; B = '0;

    #12;
    chk("rst_in_ready",  32'(ir1), 32'd1);
    chk("rst_out_valid", 32'(ov1), 32'd0);
    chk("rst_y",         y1,       32'd0);
    chk("rst_z",         32'(z1),  32'd1);
    chk("rst_aluop",     32'(op1), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", 32'(ir1), 32'd1);

    for (int i = 0; i < NV; i++) begin
      run_op(1'b0, tbl[i], ry, rz, rop, rlat);
      chk($sformatf("v%0d_y", i),   ry,         tbl[i].exp_y);
      chk($sformatf("v%0d_z", i),   32'(rz),    32'(tbl[i].exp_z));
      chk($sformatf("v%0d_op", i),  32'(rop),   32'(tbl[i].exp_op));
      chk($sformatf("v%0d_lat", i), 32'(rlat),  32'(tbl[i].exp_lat));
    end

    for (int i = 0; i < 3; i++) begin
      run_op(1'b1, tbl8[i], ry, rz, rop, rlat);
      chk($sformatf("s8_%0d_y", i),   ry,        tbl8[i].exp_y);
      chk($sformatf("s8_%0d_op", i),  32'(rop),  32'(tbl8[i].exp_op));
      chk($sformatf("s8_%0d_lat", i), 32'(rlat), 32'(tbl8[i].exp_lat));
    end

    // Backpressure: result held in DONE, a stray request is ignored.
    drive(tbl[0]);
    iv1 = 1'b1;
    @(posedge clk); #1;
    iv1 = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("bp%0d_valid", c),    32'(ov1), 32'd1);
      chk($sformatf("bp%0d_in_ready", c), 32'(ir1), 32'd0);
      chk($sformatf("bp%0d_y", c),        y1,       32'd8);
      chk($sformatf("bp%0d_z", c),        32'(z1),  32'd0);
      chk($sformatf("bp%0d_op", c),       32'(op1), 32'd0);
      if (c == 1) begin
        v = tbl[2]; v.a = 32'd100; v.b = 32'd200;
        drive(v);
        iv1 = 1'b1;
      end else begin
        iv1 = 1'b0;
      end
      @(posedge clk); #1;
    end
    iv1 = 1'b0;
    chk("bp_hold_y",  y1,       32'd8);
    chk("bp_hold_op", 32'(op1), 32'd0);
    or1 = 1'b1;
    @(posedge clk); #1;
    or1 = 1'b0;
    chk("bp_release_in_ready",  32'(ir1), 32'd1);
    chk("bp_release_out_valid", 32'(ov1), 32'd0);
    @(posedge clk); #1;
    chk("bp_no_ghost_op", 32'(ov1), 32'd0);

    // Reset in the middle of a 31-step SLL.
    drive(tbl[13]);
    iv1 = 1'b1;
    @(posedge clk); #1;
    iv1 = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    chk("mid_shift_busy", 32'(ir1), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(ov1), 32'd0);
    chk("mid_rst_y",         y1,       32'd0);
    chk("mid_rst_z",         32'(z1),  32'd1);
    chk("mid_rst_aluop",     32'(op1), 32'd0);
    chk("mid_rst_in_ready",  32'(ir1), 32'd1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("after_rst_in_ready",  32'(ir1), 32'd1);
    chk("after_rst_out_valid", 32'(ov1), 32'd0);
    v = tbl[0]; v.a = 32'd1; v.b = 32'd1;
    run_op(1'b0, v, ry, rz, rop, rlat);
    chk("after_rst_add_y",   ry,        32'd2);
    chk("after_rst_add_lat", 32'(rlat), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
